fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of async_fifo between N_REQ requesters in the write clock domain.
//  Arbitration is round-robin. Each grant is locked for a burst, which ends on req_last or after
//  MAX_BURST beats. Write strobes are gated by fifo_full, so a beat is accepted only when the FIFO
//  takes it and no data is ever dropped.
// PARAMETERS
//  DATA_WIDTH  8  width of each requester's data and of wr_data
//  N_REQ       4  number of requesters (2..16)
//  MAX_BURST   8  max beats per grant before forced rotation (>=1)
//  CNT_WIDTH   4  beat counter width; must hold MAX_BURST
// PORTS
//  wr_clk     in   1                 write-domain clock, rising edge
//  wr_rst_n   in   1                 async active-low reset
//  req_valid  in   N_REQ             per-requester data valid
//  req_last   in   N_REQ             per-requester last beat of burst (qualified by valid)
//  req_data   in   N_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready  out  N_REQ             beat accepted this cycle when valid&ready
//  fifo_full  in   1                 FIFO full flag, same domain
//  wr_en      out  1                 FIFO write enable
//  wr_data    out  DATA_WIDTH        FIFO write data
//  grant      out  N_REQ             one-hot current owner, 0 when idle
//  busy       out  1                 1 while in BURST
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE; grant=0; rr_ptr=0; beat_cnt=0.
//   - Outputs req_ready=0, wr_en=0, wr_data=0, busy=0.
//   - Reset is honoured mid-burst; the partial burst is abandoned and nothing is written after assertion.
//  FSM IDLE -> BURST:
//   - Taken at the first edge with |req_valid.
//   - Winner is the first i with req_valid[i], searching i = rr_ptr, rr_ptr+1, ... modulo N_REQ.
//   - grant is registered as one-hot(winner) and beat_cnt is cleared.
//   - Arbitration latency: 1 cycle from req_valid to grant.
//  FSM BURST:
//   - Combinational outputs:
//       req_ready = grant & {N_REQ{~fifo_full}}
//       wr_en     = |(grant & req_valid) & ~fifo_full
//       wr_data   = req_data of the granted requester when wr_en, else 0
//   - Accepted beat = wr_en. It increments beat_cnt (CNT_WIDTH, no wrap past MAX_BURST).
//  FSM BURST -> IDLE:
//   - Taken at the edge where an accepted beat has req_last of the owner, or beat_cnt+1 == MAX_BURST.
//   - On exit: grant=0, rr_ptr = owner+1 (wraps N_REQ-1 -> 0).
//   - One idle/arbitration cycle separates consecutive bursts.
//  Owner deasserts req_valid mid-burst:
//   - Grant stays locked; no beat is counted.
//   - Others wait; there is no timeout.
//  fifo_full=1:
//   - req_ready=0 and wr_en=0 in the same cycle.
//   - beat_cnt and grant hold; the owner's data must stay stable.
//  Non-owner signals: req_valid/req_last of non-owners are ignored; their req_ready stays 0.
//  Single requester, MAX_BURST=1: grant toggles on/off every other cycle (50% throughput).
// TESTING
//  1 Reset: assert wr_rst_n=0 mid-traffic -> all outputs 0 same cycle; after release, grant=0 and busy=0.
//  2 Single burst:
//    - Stimulus: req 0 sends 0xA0,0xA1,0xA2 with last on 0xA2, fifo_full=0.
//    - Response: grant=0001 one cycle after valid; wr_en high 3 cycles with those data; then IDLE, rr_ptr=1.
//  3 Round-robin: all 4 valid, last=1 every beat -> grant sequence 0001,0010,0100,1000,0001; one beat per 2 cycles.
//  4 Backpressure:
//    - Stimulus: fifo_full=1 for 2 cycles during beat 2 of a 4-beat burst.
//    - Response: wr_en=0 and req_ready=0 those cycles; all 4 beats written in order, none duplicated.
//  5 Forced rotation:
//    - Stimulus: req 2 never asserts last, req 3 valid.
//    - Response: after exactly 8 accepted beats, grant moves 0100->0 then 1000.
//    - Variant, req 3 idle: req 2 is re-granted.
//  6 Stall lock: owner drops valid for 3 cycles mid-burst while req 1 is valid -> grant unchanged, wr_en=0, beat_cnt holds.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the async_fifo write port
// between N_REQ write-domain requesters. A grant is held for a whole burst,
// which ends on the owner's last beat or after MAX_BURST accepted beats.
// Beats are only accepted while the FIFO is not full, so nothing is dropped.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4,
    parameter int MAX_BURST  = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                        wr_clk,
    input  logic                        wr_rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_last,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        fifo_full,
    output logic                        wr_en,
    output logic [DATA_WIDTH-1:0]       wr_data,
    output logic [N_REQ-1:0]            grant,
    output logic                        busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic [N_REQ-1:0]       grant_q;
    logic [PTR_W-1:0]       owner_q;
    logic [PTR_W-1:0]       rr_ptr;
    logic [CNT_WIDTH-1:0]   beat_cnt;

    logic [PTR_W-1:0]       win_idx;
    logic                   burst_done;
    logic [DATA_WIDTH-1:0]  req_data_arr [N_REQ];

    // Unpack the flat requester data bus into one word per requester
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo N_REQ
    always_comb begin
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req_valid[PTR_W'(idx)]) begin
                found   = 1'b1;
                win_idx = PTR_W'(idx);
            end
        end
    end

    // State register; reset abandons any burst in progress immediately
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: arbitrate when anyone is valid, leave BURST on the final accepted beat
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    next_state = BURST;
                end
            end
            BURST: begin
                if (burst_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output logic: only the owner sees ready, and both ready and the write are gated by fifo_full
    always_comb begin
        req_ready  = '0;
        wr_en      = 1'b0;
        wr_data    = '0;
        busy       = 1'b0;
        burst_done = 1'b0;
        if (state == BURST) begin
            busy      = 1'b1;
            req_ready = grant_q & {N_REQ{~fifo_full}};
            wr_en     = (|(grant_q & req_valid)) & ~fifo_full;
            if (wr_en) begin
                wr_data    = req_data_arr[owner_q];
                burst_done = req_last[owner_q] || ((int'(beat_cnt) + 1) == MAX_BURST);
            end
        end
    end

    assign grant = grant_q;

    // Grant, owner, round-robin pointer and beat counter bookkeeping
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_q  <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                        owner_q  <= win_idx;
                        beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (wr_en && (int'(beat_cnt) < MAX_BURST)) begin
                        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                    end
                    if (burst_done) begin
                        grant_q <= '0;
                        if (owner_q == PTR_W'(N_REQ - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= owner_q + PTR_W'(1);
                        end
                    end
                end
                default: begin
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule
